// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - wide add/subtract sequenced through one shared 4-bit CLA slice
// One operation in flight; the slice processes one nibble per cycle, LSB first.

module nibble_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Fully flattened lookahead so no carry ripples inside the slice.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s     = p ^ c[3:0];
    assign c_out = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c_in,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   sum_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q;
    logic           a_msb_q;
    logic           b_msb_q;
    logic           c_out_q;
    logic           ovf_q;

    logic [3:0]     slice_s;
    logic           slice_c_out;
    logic           accept;
    logic           last_nibble;
    logic [W-1:0]   b_eff;

    // Operands shift right each RUN cycle so the slice always reads bits [3:0].
    nibble_cla4 u_slice (
        .a     (a_q[3:0]),
        .b     (b_q[3:0]),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_c_out)
    );

    assign b_eff       = sub ? ~b : b;
    assign accept      = in_valid && in_ready;
    assign last_nibble = (idx_q == IW'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_nibble) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b_eff;
                carry_q <= sub ? 1'b1 : c_in;
                a_msb_q <= a[W-1];
                b_msb_q <= b_eff[W-1];
                idx_q   <= '0;
            end else if (state_q == S_RUN) begin
                a_q                <= a_q >> 4;
                b_q                <= b_q >> 4;
                carry_q            <= slice_c_out;
                sum_q[4*idx_q +: 4] <= slice_s;
                if (last_nibble) begin
                    c_out_q <= slice_c_out;
                    // slice_s[3] is the result sign bit on the final nibble.
                    ovf_q   <= (a_msb_q == b_msb_q) && (slice_s[3] != a_msb_q);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - scoreboard bench for nibble_serial_adder_ctrl (NIBBLES=8 and 1)
module tb_nibble_serial_adder_ctrl;
    localparam int N = 8;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, c_in, sub;
    logic [W-1:0] a, b, sum;
    logic         out_valid, out_ready, c_out, ovf, busy;

    logic         p_in_valid, p_in_ready, p_c_in, p_sub;
    logic [3:0]   p_a, p_b, p_sum;
    logic         p_out_valid, p_out_ready, p_c_out, p_ovf, p_busy;

    exp_t       sb[$];
    logic [5:0] sb1[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .a(p_a), .b(p_b), .c_in(p_c_in), .sub(p_sub), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .sum(p_sum), .c_out(p_c_out), .ovf(p_ovf), .busy(p_busy)
    );

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        logic [W-1:0] be;
        logic [W:0]   t;
        exp_t         e;
        be    = s ? ~y : y;
        t     = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        e.sum = t[W-1:0];
        e.c   = t[W];
        e.v   = (x[W-1] == be[W-1]) && (e.sum[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic accept_op(input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic s, input bit push,
                             input exp_t e, output int acc);
        bit done;
        done = 0;
        a = x; b = y; c_in = ci; sub = s; in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        acc = cyc;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
        end else if (push) begin
            sb.push_back(e);
        end
    endtask

    // Edge count includes the accept edge itself.
    task automatic wait_done(output int edges);
        edges = 1;
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL done_timeout out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
        if (sum !== '0)         begin errors++; $display("FAIL rst_sum got %h want 0", sum); end
        if (c_out !== 1'b0)     begin errors++; $display("FAIL rst_c_out got %0b want 0", c_out); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL rst_ovf got %0b want 0", ovf); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
        if (p_in_ready !== 1'b1) begin errors++; $display("FAIL rst_p_in_ready got %0b want 1", p_in_ready); end
    endtask

    task automatic test_basic();
        logic [W-1:0] ta [4] = '{32'hFFFFFFFF, 32'h00000005, 32'h7FFFFFFF, 32'h80000000};
        logic [W-1:0] tb [4] = '{32'h00000001, 32'h00000007, 32'h00000001, 32'h00000001};
        logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         ts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_t         te [4] = '{{32'h00000000, 1'b1, 1'b0}, {32'hFFFFFFFE, 1'b0, 1'b0},
                                 {32'h80000000, 1'b0, 1'b1}, {32'h7FFFFFFF, 1'b1, 1'b1}};
        int   acc, edges;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            accept_op(ta[i], tb[i], tc[i], ts[i], 1'b1, te[i], acc);
            checks += 2;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL basic%0d_in_ready_run got %0b want 0", i, in_ready); end
            if (busy !== 1'b1)     begin errors++; $display("FAIL basic%0d_busy_run got %0b want 1", i, busy); end
            wait_done(edges);
            checks++;
            if (edges != N + 1) begin errors++; $display("FAIL basic%0d_latency got %0d want %0d", i, edges, N + 1); end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks += 3;
                if (sum !== e.sum) begin errors++; $display("FAIL basic%0d_sum got %h want %h", i, sum, e.sum); end
                if (c_out !== e.c) begin errors++; $display("FAIL basic%0d_c_out got %0b want %0b", i, c_out, e.c); end
                if (ovf !== e.v)   begin errors++; $display("FAIL basic%0d_ovf got %0b want %0b", i, ovf, e.v); end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks += 2;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL basic%0d_out_valid_drop got %0b want 0", i, out_valid); end
            if (sum !== te[i].sum)  begin errors++; $display("FAIL basic%0d_sum_kept got %h want %h", i, sum, te[i].sum); end
        end
    endtask

    task automatic test_hold();
        int   acc, edges;
        exp_t e;
        accept_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1,
                  model(32'h12345678, 32'h11111111, 1'b0, 1'b0), acc);
        wait_done(edges);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        a = 32'h00000001; b = 32'h00000001; c_in = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks += 5;
            if (sum !== e.sum)      begin errors++; $display("FAIL hold%0d_sum got %h want %h", i, sum, e.sum); end
            if (c_out !== e.c)      begin errors++; $display("FAIL hold%0d_c_out got %0b want %0b", i, c_out, e.c); end
            if (ovf !== e.v)        begin errors++; $display("FAIL hold%0d_ovf got %0b want %0b", i, ovf, e.v); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_out_valid got %0b want 1", i, out_valid); end
            if (in_ready !== 1'b0)  begin errors++; $display("FAIL hold%0d_in_ready got %0b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready got %0b want 1", in_ready); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL hold_release_busy got %0b want 0", busy); end
        accept_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, model(32'h1, 32'h1, 1'b0, 1'b0), acc);
        wait_done(edges);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (sum !== e.sum) begin errors++; $display("FAIL hold_next_sum got %h want %h", sum, e.sum); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   acc, edges;
        exp_t e;
        accept_op(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0, 1'b0, '0, acc);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %0b want 0", out_valid); end
        if (sum !== '0)         begin errors++; $display("FAIL midrst_sum got %h want 0", sum); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
        if (c_out !== 1'b0)     begin errors++; $display("FAIL midrst_c_out got %0b want 0", c_out); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL midrst_ovf got %0b want 0", ovf); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_partial got %0b want 0", out_valid); end
        accept_op(32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1, '{32'h00000003, 1'b0, 1'b0}, acc);
        wait_done(edges);
        checks++;
        if (edges != N + 1) begin errors++; $display("FAIL midrst_latency got %0d want %0d", edges, N + 1); end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 3;
            if (sum !== e.sum) begin errors++; $display("FAIL midrst_sum3 got %h want %h", sum, e.sum); end
            if (c_out !== e.c) begin errors++; $display("FAIL midrst_c_out3 got %0b want %0b", c_out, e.c); end
            if (ovf !== e.v)   begin errors++; $display("FAIL midrst_ovf3 got %0b want %0b", ovf, e.v); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int           acc, prev, edges;
        logic [W-1:0] x, y;
        logic         ci, s;
        exp_t         e;
        prev = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x  = $urandom; y = $urandom;
            ci = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            if (i == 0) begin x = 32'h80000000; y = 32'h80000000; s = 1'b0; end
            accept_op(x, y, ci, s, 1'b1, model(x, y, ci, s), acc);
            if (prev >= 0) begin
                checks++;
                if (acc - prev != N + 2) begin errors++; $display("FAIL b2b%0d_interval got %0d want %0d", i, acc - prev, N + 2); end
            end
            prev = acc;
            wait_done(edges);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks += 3;
                if (sum !== e.sum) begin errors++; $display("FAIL b2b%0d_sum got %h want %h", i, sum, e.sum); end
                if (c_out !== e.c) begin errors++; $display("FAIL b2b%0d_c_out got %0b want %0b", i, c_out, e.c); end
                if (ovf !== e.v)   begin errors++; $display("FAIL b2b%0d_ovf got %0b want %0b", i, ovf, e.v); end
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_nibbles1();
        logic [3:0] ta [2] = '{4'hF, 4'h7};
        logic [3:0] tb [2] = '{4'h1, 4'h1};
        logic       tc [2] = '{1'b1, 1'b0};
        logic [5:0] te [2] = '{{4'h1, 1'b1, 1'b0}, {4'h8, 1'b0, 1'b1}};
        logic [5:0] e;
        int         edges;
        for (int i = 0; i < 2; i++) begin
            p_a = ta[i]; p_b = tb[i]; p_c_in = tc[i]; p_sub = 1'b0; p_in_valid = 1'b1;
            checks++;
            if (p_in_ready !== 1'b1) begin errors++; $display("FAIL n1_%0d_in_ready got %0b want 1", i, p_in_ready); end
            @(posedge clk); #1;
            p_in_valid = 1'b0;
            sb1.push_back(te[i]);
            edges = 1;
            for (int k = 0; k < 20 && !p_out_valid; k++) begin
                @(posedge clk); #1;
                edges++;
            end
            checks += 4;
            if (edges != 2) begin errors++; $display("FAIL n1_%0d_latency got %0d want 2", i, edges); end
            e = sb1.pop_front();
            if (p_sum !== e[5:2])  begin errors++; $display("FAIL n1_%0d_sum got %h want %h", i, p_sum, e[5:2]); end
            if (p_c_out !== e[1])  begin errors++; $display("FAIL n1_%0d_c_out got %0b want %0b", i, p_c_out, e[1]); end
            if (p_ovf !== e[0])    begin errors++; $display("FAIL n1_%0d_ovf got %0b want %0b", i, p_ovf, e[0]); end
            p_out_ready = 1'b1;
            @(posedge clk); #1;
            p_out_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
        p_in_valid = 1'b0; p_a = '0; p_b = '0; p_c_in = 1'b0; p_sub = 1'b0; p_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_nibbles1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
